seqdet_arb_ctrl: RTL and testbench

SEQDET_ARB_CTRL -- requirements
Module: seqdet_arb_ctrl

---
 rtl/seqdet_arb_ctrl.sv | 146 ++++++++++++++
 tb/tb_seqdet_arb_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seqdet_arb_ctrl.sv
// seqdet_arb_ctrl: two-channel round-robin arbiter feeding a serial pattern detector.
// A granted request word is shifted MSB first through a 4-bit pattern detector.
// The number of matches and the source channel are then reported through a
// valid/ready handshake.
// Build option: define SEQDET_OVERLAP_EN to let matches overlap. When it is
// undefined, the detector fill is cleared after each match.
//
// state  | meaning
// IDLE   | waiting for a request; in_ready asserted for the granted channel
// SHIFT  | feeding one word bit per cycle into the detector
// REPORT | holding the result until res_ready
module seqdet_arb_ctrl #(
    parameter int          WIDTH   = 8,
    parameter logic [3:0]  PATTERN = 4'b1011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    output logic [1:0]       in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_count,
    output logic             res_chan,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       hist_q, hist_d;
    logic [1:0]       fill_q, fill_d;
    logic [3:0]       count_q, count_d;
    logic             chan_q, chan_d;
    logic             last_q, last_d;

    logic             grant;
    logic             cur_bit;
    logic             match;

    // Tie goes to the channel not served last; a lone request always wins.
    always_comb begin
        grant = ~last_q;
        if (in_valid == 2'b01) begin
            grant = 1'b0;
        end else if (in_valid == 2'b10) begin
            grant = 1'b1;
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        count_d  = count_q;
        chan_d   = chan_q;
        last_d   = last_q;
        in_ready = 2'b00;
        cur_bit  = word_q[WIDTH-1];
        match    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!reset && (in_valid != 2'b00)) begin
                    in_ready[grant] = 1'b1;
                    word_d  = grant ? in_data1 : in_data0;
                    chan_d  = grant;
                    last_d  = grant;
                    count_d = 4'd0;
                    fill_d  = 2'd0;
                    hist_d  = 3'd0;
                    cnt_d   = 4'(WIDTH - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                match  = (fill_q == 2'd3) && ({hist_q, cur_bit} == PATTERN);
                word_d = word_q << 1;
                hist_d = {hist_q[1:0], cur_bit};
                if (fill_q != 2'd3) begin
                    fill_d = fill_q + 2'd1;
                end
                if (match) begin
                    count_d = count_q + 4'd1;
`ifdef SEQDET_OVERLAP_EN
                    fill_d  = fill_q;
`else
                    fill_d  = 2'd0;
`endif
                end
                if (cnt_q == 4'd0) begin
                    state_d = REPORT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res_valid = (state_q == REPORT);
    assign res_count = count_q;
    assign res_chan  = chan_q;
    assign busy      = (state_q != IDLE);

    // State and datapath registers; reset leaves channel 0 winning the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= 4'd0;
            hist_q  <= 3'd0;
            fill_q  <= 2'd0;
            count_q <= 4'd0;
            chan_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_seqdet_arb_ctrl.sv
// Directed bench for seqdet_arb_ctrl (WIDTH=8, PATTERN=1011).
module tb_seqdet_arb_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic [1:0]       in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [1:0]       in_ready;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_count;
    logic             res_chan;
    logic             busy;

    int checks;
    int failures;

`ifdef SEQDET_OVERLAP_EN
    localparam logic [3:0] EXP_B6 = 4'd2;
`else
    localparam logic [3:0] EXP_B6 = 4'd1;
`endif

    seqdet_arb_ctrl #(.WIDTH(WIDTH), .PATTERN(4'b1011)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_count (res_count),
        .res_chan  (res_chan),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until res_valid, returning the number of edges taken (bounded).
    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    // Single request on one channel with res_ready held high.
    task automatic test_request(input bit ch, input logic [7:0] d, input logic [3:0] exp_cnt,
                                input string nm);
        int n;
        res_ready = 1'b1;
        if (ch) in_data1 = d; else in_data0 = d;
        in_valid = ch ? 2'b10 : 2'b01;
        #1;
        checks++;
        if (in_ready !== (ch ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL %s in_ready got=%b exp=%b", nm, in_ready, ch ? 2'b10 : 2'b01);
        end
        step();
        in_valid = 2'b00;
        checks++;
        if (busy !== 1'b1 || in_ready !== 2'b00) begin
            failures++;
            $display("FAIL %s shift busy=%b in_ready=%b exp busy=1 in_ready=00", nm, busy, in_ready);
        end
        wait_res(n);
        checks++;
        if (n != WIDTH) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", nm, n, WIDTH);
        end
        checks++;
        if (res_count !== exp_cnt || res_chan !== ch) begin
            failures++;
            $display("FAIL %s result count=%0d chan=%b exp count=%0d chan=%b",
                     nm, res_count, res_chan, exp_cnt, ch);
        end
        step();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_count !== exp_cnt) begin
            failures++;
            $display("FAIL %s after busy=%b res_valid=%b count=%0d exp 0 0 %0d",
                     nm, busy, res_valid, res_count, exp_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 2'b11;
        res_ready = 1'b1;
        step();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 2'b00 || res_count !== 4'd0) begin
            failures++;
            $display("FAIL reset res_valid=%b busy=%b in_ready=%b count=%0d exp 0 0 00 0",
                     res_valid, busy, in_ready, res_count);
        end
        step();
        in_valid = 2'b00;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_tie();
        int n;
        in_data0 = 8'hB6;
        in_data1 = 8'hBB;
        in_valid = 2'b11;
        #1;
        checks++;
        if (in_ready !== 2'b01) begin
            failures++;
            $display("FAIL tie_first in_ready got=%b exp=01", in_ready);
        end
        step();
        in_valid = 2'b10;
        wait_res(n);
        checks++;
        if (res_chan !== 1'b0 || res_count !== EXP_B6) begin
            failures++;
            $display("FAIL tie_first result chan=%b count=%0d exp chan=0 count=%0d",
                     res_chan, res_count, EXP_B6);
        end
        step();
        checks++;
        if (in_ready !== 2'b10) begin
            failures++;
            $display("FAIL tie_second in_ready got=%b exp=10", in_ready);
        end
        step();
        in_valid = 2'b11;
        wait_res(n);
        checks++;
        if (res_chan !== 1'b1 || res_count !== 4'd2) begin
            failures++;
            $display("FAIL tie_second result chan=%b count=%0d exp chan=1 count=2", res_chan, res_count);
        end
        step();
        checks++;
        if (in_ready !== 2'b01) begin
            failures++;
            $display("FAIL tie_third in_ready got=%b exp=01", in_ready);
        end
        in_valid = 2'b00;
        #1;
    endtask

    task automatic test_stall();
        int n;
        in_data1 = 8'hBB;
        in_valid = 2'b10;
        res_ready = 1'b0;
        step();
        in_valid = 2'b11;
        wait_res(n);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_count !== 4'd2 || res_chan !== 1'b1 || in_ready !== 2'b00) begin
                failures++;
                $display("FAIL stall cyc%0d res_valid=%b count=%0d chan=%b in_ready=%b exp 1 2 1 00",
                         i, res_valid, res_count, res_chan, in_ready);
            end
            step();
        end
        in_valid = 2'b00;
        res_ready = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold res_valid got=%b exp=1", res_valid);
        end
        step();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release busy=%b res_valid=%b exp 0 0", busy, res_valid);
        end
    endtask

    task automatic test_abort();
        in_data0 = 8'hBB;
        in_valid = 2'b01;
        step();
        in_valid = 2'b00;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_count !== 4'd0) begin
            failures++;
            $display("FAIL abort busy=%b res_valid=%b count=%0d exp 0 0 0", busy, res_valid, res_count);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (res_valid !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_result cyc%0d res_valid got=%b exp=0", i, res_valid);
            end
        end
        test_request(1'b0, 8'hB6, EXP_B6, "after_abort");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        in_valid = 2'b00;
        in_data0 = '0;
        in_data1 = '0;
        res_ready = 1'b1;
        test_reset();
        test_request(1'b0, 8'hB6, EXP_B6, "ch0_B6");
        test_request(1'b1, 8'hBB, 4'd2, "ch1_BB");
        test_request(1'b0, 8'h00, 4'd0, "ch0_00");
        test_request(1'b1, 8'hFF, 4'd0, "ch1_FF");
        test_reset();
        test_tie();
        test_stall();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
